// File: rtl/pulse_divider.sv
`default_nettype none
// ============================================================================
// Module      : pulse_divider
// Description : Programmable event divider. Counts rising edges of in_pulse
//               and emits a one-clock out_pulse each time the loaded number of
//               events has elapsed. Supports one-shot / auto-reload, event
//               gating and stop-by-load (load with start = 0).
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH       counter / period width in bits (2..16)
//   SYNC_IN     1 = two-flop synchroniser on in_pulse, 0 = in_pulse is
//               already synchronous to clk
// Ports
//   clk         system clock, rising edge active
//   resetn      asynchronous active-low reset
//   in_pulse    event input, each rising edge is one event
//   start       period, sampled only while load = 1
//   load        strobe: latch start and (re)start; start = 0 stops
//   enable      1 = count events, 0 = discard events
//   auto_reload 1 = reload period after terminal count, 0 = one-shot
//   out_pulse   one-cycle pulse at terminal count (registered)
//   pos_value   events remaining until next out_pulse (registered)
//   busy        high while counting (registered)
// ============================================================================
module pulse_divider #(
  parameter int WIDTH   = 4,
  parameter bit SYNC_IN = 1'b1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_pulse,
  input  logic [WIDTH-1:0] start,
  input  logic             load,
  input  logic             enable,
  input  logic             auto_reload,
  output logic             out_pulse,
  output logic [WIDTH-1:0] pos_value,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] C_ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] C_ZERO = '0;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] per_q, per_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             out_pulse_q, out_pulse_d;
  logic             busy_q, busy_d;
  logic             prev_q;
  logic             w_in;
  logic             w_ev;

  // --------------------------------------------------------------------------
  // Input conditioning. With the synchroniser present the event reaches the
  // counter two edges after in_pulse is first sampled high.
  // --------------------------------------------------------------------------
  generate
    if (SYNC_IN) begin : g_sync
      logic s1_q;
      logic s2_q;

      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          s1_q <= 1'b0;
          s2_q <= 1'b0;
        end else begin
          s1_q <= in_pulse;
          s2_q <= s1_q;
        end
      end

      assign w_in = s2_q;
    end else begin : g_direct
      assign w_in = in_pulse;
    end
  endgenerate

  // Edge history tracks the input every cycle, independent of state and
  // enable, so an input held high across a load or gate never re-triggers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= w_in;
    end
  end

  assign w_ev = w_in & ~prev_q;

  // --------------------------------------------------------------------------
  // Next-state logic. load has priority over counting, so an event in the
  // same cycle as a load is dropped.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    per_d       = per_q;
    rem_d       = rem_q;
    out_pulse_d = 1'b0;

    if (load) begin
      if (start != C_ZERO) begin
        per_d   = start;
        rem_d   = start;
        state_d = ST_RUN;
      end else begin
        per_d   = C_ZERO;
        rem_d   = C_ZERO;
        state_d = ST_IDLE;
      end
    end else if ((state_q == ST_RUN) && w_ev && enable) begin
      if (rem_q > C_ONE) begin
        // Only reachable with rem >= 2, so the counter cannot wrap.
        rem_d = rem_q - C_ONE;
      end else begin
        out_pulse_d = 1'b1;
        if (auto_reload) begin
          rem_d = per_q;
        end else begin
          rem_d   = C_ZERO;
          state_d = ST_DONE;
        end
      end
    end

    // busy is registered from the next state so it changes at the same edge
    // as the load or terminal count that causes it.
    busy_d = (state_d == ST_RUN);
  end

  // --------------------------------------------------------------------------
  // State and output registers.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      per_q       <= '0;
      rem_q       <= '0;
      out_pulse_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      per_q       <= per_d;
      rem_q       <= rem_d;
      out_pulse_q <= out_pulse_d;
      busy_q      <= busy_d;
    end
  end

  assign out_pulse = out_pulse_q;
  assign pos_value = rem_q;
  assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_pulse_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_pulse_divider
// Description : Directed self-checking bench. Two dividers (WIDTH=8) share
//               all inputs: one with the input synchroniser, one without.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pulse_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         resetn;
  logic         in_pulse;
  logic [W-1:0] start;
  logic         load;
  logic         enable;
  logic         auto_reload;

  logic         op_s, op_d;
  logic         busy_s, busy_d;
  logic [W-1:0] pos_s, pos_d;

  int n_cmp = 0;
  int n_mis = 0;
  int cnt_s = 0;
  int cnt_d = 0;

  always #5 clk = ~clk;

  pulse_divider #(.WIDTH(W), .SYNC_IN(1'b1)) u_dut_sync (
    .clk         (clk),
    .resetn      (resetn),
    .in_pulse    (in_pulse),
    .start       (start),
    .load        (load),
    .enable      (enable),
    .auto_reload (auto_reload),
    .out_pulse   (op_s),
    .pos_value   (pos_s),
    .busy        (busy_s)
  );

  pulse_divider #(.WIDTH(W), .SYNC_IN(1'b0)) u_dut_direct (
    .clk         (clk),
    .resetn      (resetn),
    .in_pulse    (in_pulse),
    .start       (start),
    .load        (load),
    .enable      (enable),
    .auto_reload (auto_reload),
    .out_pulse   (op_d),
    .pos_value   (pos_d),
    .busy        (busy_d)
  );

  // Count out_pulse cycles, sampled mid-cycle.
  always @(negedge clk) begin
    if (op_s === 1'b1) cnt_s++;
    if (op_d === 1'b1) cnt_d++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int pos, input int bsy, input int cnt);
    chk({tag, " pos_s"},  32'(pos_s),  pos);
    chk({tag, " pos_d"},  32'(pos_d),  pos);
    chk({tag, " busy_s"}, 32'(busy_s), bsy);
    chk({tag, " busy_d"}, 32'(busy_d), bsy);
    chk({tag, " cnt_s"},  cnt_s,       cnt);
    chk({tag, " cnt_d"},  cnt_d,       cnt);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One event: high for one clock, low for three, so both variants settle.
  task automatic event_pulse();
    in_pulse = 1'b1;
    tick();
    in_pulse = 1'b0;
    tick();
    tick();
    tick();
  endtask

  task automatic do_load(input logic [W-1:0] v);
    start = v;
    load  = 1'b1;
    tick();
    load  = 1'b0;
  endtask

  int exp_pos1 [7] = '{2, 1, 3, 2, 1, 3, 2};
  int exp_cnt1 [7] = '{0, 0, 1, 1, 1, 2, 2};
  int exp_pos2 [4] = '{1, 0, 0, 0};
  int exp_bsy2 [4] = '{1, 0, 0, 0};
  int exp_cnt2 [4] = '{2, 3, 3, 3};

  initial begin
    resetn      = 1'b0;
    in_pulse    = 1'b0;
    load        = 1'b0;
    enable      = 1'b1;
    auto_reload = 1'b1;
    start       = '0;
    #12;
    chk_all("reset", 0, 0, 0);
    chk("reset op_s", 32'(op_s), 0);
    chk("reset op_d", 32'(op_d), 0);
    resetn = 1'b1;
    tick();

    // Auto-reload, period 3, seven events.
    do_load(8'd3);
    chk_all("ar3 load", 3, 1, 0);
    for (int i = 0; i < 7; i++) begin
      event_pulse();
      chk_all($sformatf("ar3 ev%0d", i + 1), exp_pos1[i], 1, exp_cnt1[i]);
    end

    // One-shot, period 2, four events.
    auto_reload = 1'b0;
    do_load(8'd2);
    chk_all("os2 load", 2, 1, 2);
    for (int i = 0; i < 4; i++) begin
      event_pulse();
      chk_all($sformatf("os2 ev%0d", i + 1), exp_pos2[i], exp_bsy2[i], exp_cnt2[i]);
    end

    // Gating: events with enable low are discarded.
    auto_reload = 1'b1;
    enable      = 1'b0;
    do_load(8'd5);
    event_pulse();
    event_pulse();
    chk_all("gated", 5, 1, 3);
    enable = 1'b1;
    start  = 8'd9;            // no load: must have no effect
    event_pulse();
    chk_all("start w/o load", 4, 1, 3);

    // Event coincident with load at the direct input: direct discards it,
    // synchronised copy sees its event two edges later and counts it.
    in_pulse = 1'b1;
    start    = 8'd4;
    load     = 1'b1;
    tick();
    load     = 1'b0;
    in_pulse = 1'b0;
    tick();
    tick();
    tick();
    chk("coinc direct pos_d", 32'(pos_d), 4);
    chk("coinc direct pos_s", 32'(pos_s), 3);

    // Event aligned with load at the synchronised counter.
    in_pulse = 1'b1;
    tick();
    in_pulse = 1'b0;
    tick();
    start = 8'd4;
    load  = 1'b1;
    tick();
    load  = 1'b0;
    tick();
    tick();
    chk_all("coinc sync", 4, 1, 3);

    // Stop by load of zero mid-count.
    do_load(8'd4);
    event_pulse();
    event_pulse();
    chk_all("pre-stop", 2, 1, 3);
    do_load(8'd0);
    chk_all("stop", 0, 0, 3);
    event_pulse();
    chk_all("idle ignores ev", 0, 0, 3);

    // Restart, then asynchronous reset between clock edges.
    do_load(8'd6);
    event_pulse();
    event_pulse();
    chk_all("restart", 4, 1, 3);
    #2;
    resetn = 1'b0;
    #1;
    chk_all("async rst", 0, 0, 3);
    chk("async rst op_s", 32'(op_s), 0);
    chk("async rst op_d", 32'(op_d), 0);
    #2;
    resetn = 1'b1;
    tick();
    chk_all("post rst", 0, 0, 3);
    event_pulse();
    chk_all("post rst ev", 0, 0, 3);

    // Maximum period and input latency.
    auto_reload = 1'b1;
    enable      = 1'b1;
    do_load(8'd255);
    chk_all("max load", 255, 1, 3);
    in_pulse = 1'b1;
    tick();                   // edge k
    in_pulse = 1'b0;
    chk("lat k pos_d", 32'(pos_d), 254);
    chk("lat k pos_s", 32'(pos_s), 255);
    tick();                   // edge k+1
    chk("lat k+1 pos_s", 32'(pos_s), 255);
    tick();                   // edge k+2
    chk("lat k+2 pos_s", 32'(pos_s), 254);
    tick();
    for (int i = 0; i < 253; i++) begin
      event_pulse();
    end
    chk_all("max ev254", 1, 1, 3);

    // Event 255: terminal count and reload, out_pulse exactly one cycle.
    in_pulse = 1'b1;
    tick();                   // edge k
    in_pulse = 1'b0;
    chk("tc k op_d", 32'(op_d), 1);
    chk("tc k pos_d", 32'(pos_d), 255);
    chk("tc k op_s", 32'(op_s), 0);
    chk("tc k pos_s", 32'(pos_s), 1);
    tick();                   // edge k+1
    chk("tc k+1 op_d", 32'(op_d), 0);
    chk("tc k+1 op_s", 32'(op_s), 0);
    tick();                   // edge k+2
    chk("tc k+2 op_s", 32'(op_s), 1);
    chk("tc k+2 pos_s", 32'(pos_s), 255);
    tick();
    chk("tc k+3 op_s", 32'(op_s), 0);
    chk_all("max reload", 255, 1, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
